flash_prog_seq: RTL

- Flash program/erase sequencer for the PhantomRAM cartridge.
- Sits directly downstream of the DMA transfer engine. When that engine targets the flash bank instead of SRAM, it hands each byte here over a req/busy handshake.
- The block issues the JEDEC unlock/command write sequence on the memory bus, then polls DQ7 (data# polling) until the device finishes or a timeout expires.
- Clocked by the CPU E clock, one bus action per E cycle.

---
 rtl/flash_prog_seq.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/flash_prog_seq.sv
// rtl/flash_prog_seq.sv - JEDEC flash program/erase sequencer with DQ7 data# polling
//
// Accepts one byte-program or sector-erase request from the DMA engine, then
// issues the JEDEC unlock/command writes on the memory bus (3 E cycles per
// write). It then polls DQ7 until the device reports completion or the poll
// budget runs out.
//
// Optional build macro: FLASH_VERIFY_EN adds a one-cycle full-byte read-back
// check after a successful DQ7 match.
//
// Ports:
//   e_cpu       clock (CPU E clock), all state changes on the rising edge
//   reset_cpu   asynchronous active-high reset
//   req         request from DMA engine, only sampled in IDLE
//   cmd_erase   1 = sector erase, 0 = byte program (latched with req)
//   addr        target flash address / sector address (latched with req)
//   wdata       program byte (latched with req)
//   busy        high from the acceptance edge until the return to IDLE
//   done        one-cycle completion pulse (success or error)
//   err         sticky timeout/verify failure, cleared on the next accepted req
//   flash_addr  memory bus address
//   flash_dout  write data to flash
//   flash_drive high = drive flash_dout onto the data bus
//   flash_din   data bus read back
//   _ce_flash   chip enable, active low
//   _we_flash   write strobe, active low
//   _oe_flash   output enable, active low

module flash_prog_seq #(
  parameter int unsigned PROG_TIMEOUT  = 64,
  parameter int unsigned ERASE_TIMEOUT = 65535,
  parameter logic [18:0] UNLOCK_A1     = 19'h05555,
  parameter logic [18:0] UNLOCK_A2     = 19'h02AAA
) (
  input  logic        e_cpu,
  input  logic        reset_cpu,
  input  logic        req,
  input  logic        cmd_erase,
  input  logic [18:0] addr,
  input  logic [7:0]  wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [18:0] flash_addr,
  output logic [7:0]  flash_dout,
  output logic        flash_drive,
  input  logic [7:0]  flash_din,
  output logic        _ce_flash,
  output logic        _we_flash,
  output logic        _oe_flash
);

  localparam logic [15:0] PROG_LIM  = 16'(PROG_TIMEOUT);
  localparam logic [15:0] ERASE_LIM = 16'(ERASE_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_STROBE  = 3'd2,
    S_RECOVER = 3'd3,
    S_POLL    = 3'd4,
`ifdef FLASH_VERIFY_EN
    S_VERIFY  = 3'd5,
`endif
    S_DONE    = 3'd6
  } state_t;

  state_t      state, next;
  logic        op_erase;
  logic [18:0] op_addr;
  logic [7:0]  op_data;
  logic [2:0]  idx;
  logic [15:0] poll_cnt;
  logic        err_q;

  logic        accept, idx_inc, poll_clr, poll_inc, set_err;
  logic [18:0] seq_addr;
  logic [7:0]  seq_data;
  logic [7:0]  exp_byte;
  logic        last_write, dq7_match, timed_out;
  logic [15:0] poll_next;

  // Command table: program = AA,55,A0,data ; erase = AA,55,80,AA,55,30.
  always_comb begin
    seq_addr = UNLOCK_A1;
    seq_data = 8'hAA;
    case (idx)
      3'd0: begin seq_addr = UNLOCK_A1; seq_data = 8'hAA; end
      3'd1: begin seq_addr = UNLOCK_A2; seq_data = 8'h55; end
      3'd2: begin seq_addr = UNLOCK_A1; seq_data = op_erase ? 8'h80 : 8'hA0; end
      3'd3: begin
        seq_addr = op_erase ? UNLOCK_A1 : op_addr;
        seq_data = op_erase ? 8'hAA : op_data;
      end
      3'd4: begin seq_addr = UNLOCK_A2; seq_data = 8'h55; end
      default: begin seq_addr = op_addr; seq_data = 8'h30; end
    endcase
  end

  assign last_write = (idx == (op_erase ? 3'd5 : 3'd3));
  // An erased byte reads back as FF, so erase completion shows DQ7=1.
  assign exp_byte   = op_erase ? 8'hFF : op_data;
  assign dq7_match  = ((flash_din ^ exp_byte) & 8'h80) == 8'h00;
  // Counter saturates so a huge ERASE_TIMEOUT can never wrap past the limit.
  assign poll_next  = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;
  assign timed_out  = poll_next >= (op_erase ? ERASE_LIM : PROG_LIM);

  always_ff @(posedge e_cpu or posedge reset_cpu) begin
    if (reset_cpu) state <= S_IDLE;
    else           state <= next;
  end

  always_comb begin
    next        = state;
    busy        = 1'b1;
    done        = 1'b0;
    _ce_flash   = 1'b1;
    _we_flash   = 1'b1;
    _oe_flash   = 1'b1;
    flash_drive = 1'b0;
    flash_addr  = 19'd0;
    flash_dout  = 8'd0;
    accept      = 1'b0;
    idx_inc     = 1'b0;
    poll_clr    = 1'b0;
    poll_inc    = 1'b0;
    set_err     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (req) begin
          accept = 1'b1;
          next   = S_SETUP;
        end
      end
      S_SETUP: begin
        _ce_flash   = 1'b0;
        flash_drive = 1'b1;
        flash_addr  = seq_addr;
        flash_dout  = seq_data;
        next        = S_STROBE;
      end
      S_STROBE: begin
        _ce_flash   = 1'b0;
        _we_flash   = 1'b0;
        flash_drive = 1'b1;
        flash_addr  = seq_addr;
        flash_dout  = seq_data;
        next        = S_RECOVER;
      end
      S_RECOVER: begin
        flash_drive = 1'b1;
        flash_addr  = seq_addr;
        flash_dout  = seq_data;
        idx_inc     = 1'b1;
        if (last_write) begin
          poll_clr = 1'b1;
          next     = S_POLL;
        end else begin
          next = S_SETUP;
        end
      end
      S_POLL: begin
        _ce_flash  = 1'b0;
        _oe_flash  = 1'b0;
        flash_addr = op_addr;
        // A match on the same edge as the timeout still counts as success.
        if (dq7_match) begin
`ifdef FLASH_VERIFY_EN
          next = S_VERIFY;
`else
          next = S_DONE;
`endif
        end else begin
          poll_inc = 1'b1;
          if (timed_out) begin
            set_err = 1'b1;
            next    = S_DONE;
          end
        end
      end
`ifdef FLASH_VERIFY_EN
      S_VERIFY: begin
        _ce_flash  = 1'b0;
        _oe_flash  = 1'b0;
        flash_addr = op_addr;
        if (flash_din != exp_byte) set_err = 1'b1;
        next = S_DONE;
      end
`endif
      S_DONE: begin
        done = 1'b1;
        next = S_IDLE;
      end
      default: begin
        next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge e_cpu or posedge reset_cpu) begin
    if (reset_cpu) begin
      op_erase <= 1'b0;
      op_addr  <= 19'd0;
      op_data  <= 8'd0;
      idx      <= 3'd0;
      poll_cnt <= 16'd0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        op_erase <= cmd_erase;
        op_addr  <= addr;
        op_data  <= wdata;
        idx      <= 3'd0;
        err_q    <= 1'b0;
      end else if (idx_inc) begin
        idx <= idx + 3'd1;
      end
      if (poll_clr)      poll_cnt <= 16'd0;
      else if (poll_inc) poll_cnt <= poll_next;
      if (set_err) err_q <= 1'b1;
    end
  end

  assign err = err_q;

endmodule
